// File: rtl/des_pkg.sv
// Shared DES tables, shift schedule, permutation helpers and engine FSM state.
// Bit 1 of every DES table maps to the MSB of the corresponding [N-1:0] vector.
package des_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} des_state_e;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int E_TAB [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_TAB [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   // Encrypt rotation before rounds 1..16 (index 0 is round 1).
   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Each box is stored row-major: entry = row*16 + column.
   localparam int SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
      return r;
   endfunction

   function automatic logic [47:0] e_expand(input logic [31:0] x);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = x[32-E_TAB[i]];
      return r;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[31-i] = x[32-P_TAB[i]];
      return r;
   endfunction

   function automatic logic [3:0] sbox(input int box, input logic [5:0] six);
      return 4'(SBOX[box][{six[5], six[0], six[4:1]}]);
   endfunction

   // Decrypt walks the schedule backwards: round 1 unrotated, round n undoes S[18-n].
   function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
      int n;
      n = int'(idx) + 1;
      if (!dec)        return 2'(SHIFT[n-1]);
      else if (n == 1) return 2'd0;
      else             return 2'(SHIFT[17-n]);
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
      case (amt)
         2'd1:    return {x[26:0], x[27]};
         2'd2:    return {x[25:0], x[27:26]};
         default: return x;
      endcase
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
      case (amt)
         2'd1:    return {x[0], x[27:1]};
         2'd2:    return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Request/result bundle of the DES round engine; the engine is the slave side.
// key_err exists only when DES_KEY_PARITY_EN is defined.
interface des_round_engine_if;
   logic        start;
   logic        decrypt;
   logic [63:0] in;
   logic [63:0] key;
   logic        ready;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out;
`ifdef DES_KEY_PARITY_EN
   logic        key_err;
`endif

   modport master (
      output start, decrypt, in, key, out_ready,
      input  ready, out_valid, out
`ifdef DES_KEY_PARITY_EN
      , input key_err
`endif
   );

   modport slave (
      input  start, decrypt, in, key, out_ready,
      output ready, out_valid, out
`ifdef DES_KEY_PARITY_EN
      , output key_err
`endif
   );
endinterface

// File: rtl/des_f.sv
// DES f-function: E-expansion, subkey XOR, S1..S8, P; purely combinational.
module des_f
   import des_pkg::*;
(
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] f_o
);
   logic [47:0] x;
   logic [31:0] s_out;

   always_comb begin
      x     = e_expand(r_i) ^ k_i;
      s_out = '0;
      for (int s = 0; s < 8; s++) s_out[31-4*s -: 4] = sbox(s, x[47-6*s -: 6]);
   end

   assign f_o = p_perm(s_out);
endmodule

// File: rtl/des_key_schedule.sv
// On-the-fly DES key schedule: holds C/D, emits ROUNDS_PER_CYCLE subkeys per cycle.
// Loads PC-1(key) and direction on load_i; advances one cycle's worth of rounds on adv_i.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               load_i,
   input  logic                               dec_i,
   input  logic [63:0]                        key_i,
   input  logic                               adv_i,
   input  logic [3:0]                         rnd_i,
   output logic [ROUNDS_PER_CYCLE-1:0][47:0]  subkey_o
);
   logic [27:0] c_q, c_d, d_q, d_d;
   logic        dec_q, dec_d;
   logic [27:0] c_chain [ROUNDS_PER_CYCLE+1];
   logic [27:0] d_chain [ROUNDS_PER_CYCLE+1];
   logic [1:0]  amt;

   // Rotation happens before each round, so subkey j comes from the rotated halves.
   always_comb begin
      c_chain[0] = c_q;
      d_chain[0] = d_q;
      subkey_o   = '0;
      amt        = '0;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         amt          = shift_amt(rnd_i + 4'(j), dec_q);
         c_chain[j+1] = dec_q ? rotr28(c_chain[j], amt) : rotl28(c_chain[j], amt);
         d_chain[j+1] = dec_q ? rotr28(d_chain[j], amt) : rotl28(d_chain[j], amt);
         subkey_o[j]  = pc2({c_chain[j+1], d_chain[j+1]});
      end
   end

   always_comb begin
      c_d   = c_q;
      d_d   = d_q;
      dec_d = dec_q;
      if (load_i) begin
         {c_d, d_d} = pc1(key_i);
         dec_d      = dec_i;
      end else if (adv_i) begin
         c_d = c_chain[ROUNDS_PER_CYCLE];
         d_d = d_chain[ROUNDS_PER_CYCLE];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q   <= '0;
         d_q   <= '0;
         dec_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         d_q   <= d_d;
         dec_q <= dec_d;
      end
   end
endmodule

// File: rtl/des_round_engine.sv
// Iterative 16-round DES Feistel engine, 16/ROUNDS_PER_CYCLE cycles from accept to result.
// Result held until out_ready; start ignored while busy. DES_KEY_PARITY_EN adds key_err.
module des_round_engine
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   des_round_engine_if.slave  eng
);
   localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

   des_state_e  state_q, state_d;
   logic [31:0] l_q, l_d, r_q, r_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] out_q, out_d;
   logic        accept;

   logic [ROUNDS_PER_CYCLE-1:0][47:0] subkey;
   logic [31:0] l_c   [ROUNDS_PER_CYCLE+1];
   logic [31:0] r_c   [ROUNDS_PER_CYCLE+1];
   logic [31:0] f_out [ROUNDS_PER_CYCLE];

   assign accept = (state_q == IDLE) && eng.start;

   des_key_schedule #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_ks (
      .clk      (clk),
      .rst      (rst),
      .load_i   (accept),
      .dec_i    (eng.decrypt),
      .key_i    (eng.key),
      .adv_i    (state_q == RUN),
      .rnd_i    (cnt_q[3:0]),
      .subkey_o (subkey)
   );

   assign l_c[0] = l_q;
   assign r_c[0] = r_q;

   for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
      des_f u_f (
         .r_i (r_c[j]),
         .k_i (subkey[j]),
         .f_o (f_out[j])
      );
      assign l_c[j+1] = r_c[j];
      assign r_c[j+1] = l_c[j] ^ f_out[j];
   end

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (eng.start) begin
               l_d     = eng.in[63:32];
               r_d     = eng.in[31:0];
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            l_d   = l_c[ROUNDS_PER_CYCLE];
            r_d   = r_c[ROUNDS_PER_CYCLE];
            cnt_d = cnt_q + STEP;
            // Final swap: the result leaves as R16||L16.
            if (cnt_d == 5'd16) begin
               out_d   = {r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]};
               state_d = DONE;
            end
         end
         DONE: begin
            if (eng.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign eng.ready     = (state_q == IDLE);
   assign eng.out_valid = (state_q == DONE);
   assign eng.out       = out_q;

`ifdef DES_KEY_PARITY_EN
   logic key_err_q, key_err_d;

   // DES key bytes must have odd parity; any even byte flags the key.
   always_comb begin
      key_err_d = key_err_q;
      if (accept) begin
         key_err_d = 1'b0;
         for (int b = 0; b < 8; b++) begin
            if (!(^eng.key[63-8*b -: 8])) key_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_err_q <= 1'b0;
      else     key_err_q <= key_err_d;
   end

   assign eng.key_err = key_err_q;
`endif
endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine at ROUNDS_PER_CYCLE 1, 2 and 4 driven in lockstep.
// Known-answer vectors, latency, backpressure hold and asynchronous abort are checked.
module tb_des_round_engine;

   localparam logic [63:0] KEY        = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BADPAR = 64'h133457799BBCDFF0;
   localparam logic [63:0] PT_IP      = 64'hCC00CCFFF0AAF0AA;
   localparam logic [63:0] CT_PRE     = 64'h0A4CD99543423234;

   logic        clk;
   logic        rst;
   logic        start;
   logic        decrypt;
   logic        out_ready;
   logic [63:0] din;
   logic [63:0] key;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat1, lat2, lat4;

   des_round_engine_if if1 ();
   des_round_engine_if if2 ();
   des_round_engine_if if4 ();

   assign if1.start = start;  assign if2.start = start;  assign if4.start = start;
   assign if1.decrypt = decrypt;  assign if2.decrypt = decrypt;  assign if4.decrypt = decrypt;
   assign if1.in = din;  assign if2.in = din;  assign if4.in = din;
   assign if1.key = key;  assign if2.key = key;  assign if4.key = key;
   assign if1.out_ready = out_ready;  assign if2.out_ready = out_ready;  assign if4.out_ready = out_ready;

   des_round_engine #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .eng(if1));
   des_round_engine #(.ROUNDS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .eng(if2));
   des_round_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .eng(if4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start one operation on all three engines, scramble inputs, then wait with out_ready low.
   task automatic launch(input string tag, input logic [63:0] k, input logic [63:0] d,
                         input logic dec, input logic [63:0] exp);
      int c0;
      key     = k;
      din     = d;
      decrypt = dec;
      start   = 1'b1;
      c0      = cyc;
      tick();
      start   = 1'b0;
      key     = ~k;
      din     = ~d;
      decrypt = ~dec;
      check({tag, "_busy"}, 64'(if1.ready), 64'd0);
      lat1 = -1;
      lat2 = -1;
      lat4 = -1;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (if1.out_valid === 1'b1 && lat1 < 0) lat1 = cyc - c0;
         if (if2.out_valid === 1'b1 && lat2 < 0) lat2 = cyc - c0;
         if (if4.out_valid === 1'b1 && lat4 < 0) lat4 = cyc - c0;
      end
      check({tag, "_lat_r1"}, 64'(lat1), 64'd17);
      check({tag, "_lat_r2"}, 64'(lat2), 64'd9);
      check({tag, "_lat_r4"}, 64'(lat4), 64'd5);
      check({tag, "_out_r1"}, if1.out, exp);
      check({tag, "_out_r2"}, if2.out, exp);
      check({tag, "_out_r4"}, if4.out, exp);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_vld_r1"}, 64'(if1.out_valid), 64'd0);
      check({tag, "_rdy_r1"}, 64'(if1.ready), 64'd1);
      check({tag, "_vld_r2"}, 64'(if2.out_valid), 64'd0);
      check({tag, "_rdy_r2"}, 64'(if2.ready), 64'd1);
      check({tag, "_vld_r4"}, 64'(if4.out_valid), 64'd0);
      check({tag, "_rdy_r4"}, 64'(if4.ready), 64'd1);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      decrypt   = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      key       = '0;
      tick();
      tick();
      check("rst_rdy_r1", 64'(if1.ready), 64'd1);
      check("rst_vld_r1", 64'(if1.out_valid), 64'd0);
      check("rst_out_r1", if1.out, 64'd0);
      check("rst_rdy_r2", 64'(if2.ready), 64'd1);
      check("rst_vld_r2", 64'(if2.out_valid), 64'd0);
      check("rst_out_r2", if2.out, 64'd0);
      check("rst_rdy_r4", 64'(if4.ready), 64'd1);
      check("rst_vld_r4", 64'(if4.out_valid), 64'd0);
      check("rst_out_r4", if4.out, 64'd0);
      rst = 1'b0;
      tick();

      launch("enc", KEY, PT_IP, 1'b0, CT_PRE);
`ifdef DES_KEY_PARITY_EN
      check("enc_keyerr", 64'(if1.key_err), 64'd0);
`endif

      // Result must stay put and new requests must be refused while unacknowledged.
      for (int i = 0; i < 10; i++) begin
         start   = 1'b1;
         din     = 64'(i);
         key     = KEY;
         decrypt = 1'b1;
         tick();
         check("bp_out", if1.out, CT_PRE);
         check("bp_rdy", 64'(if1.ready), 64'd0);
         check("bp_vld", 64'(if1.out_valid), 64'd1);
      end
      start = 1'b0;
      release_out("bp");
      tick();
      check("bp_idle_rdy", 64'(if1.ready), 64'd1);
      check("bp_idle_vld", 64'(if1.out_valid), 64'd0);

      launch("dec", KEY, CT_PRE, 1'b1, PT_IP);
      release_out("dec");

      // Abort in round 7 of the single-round engine; the 4-round engine is already in DONE.
      key     = KEY;
      din     = PT_IP;
      decrypt = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      #2 rst = 1'b1;
      #1;
      check("abort_vld_r1", 64'(if1.out_valid), 64'd0);
      check("abort_rdy_r1", 64'(if1.ready), 64'd1);
      check("abort_out_r1", if1.out, 64'd0);
      check("abort_vld_r4", 64'(if4.out_valid), 64'd0);
      check("abort_out_r4", if4.out, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      launch("enc2", KEY, PT_IP, 1'b0, CT_PRE);
      release_out("enc2");

      // Parity bits are dropped by PC-1, so the datapath result is identical.
      launch("par", KEY_BADPAR, PT_IP, 1'b0, CT_PRE);
`ifdef DES_KEY_PARITY_EN
      check("par_keyerr", 64'(if1.key_err), 64'd1);
`endif
      release_out("par");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
